// File: rtl/pdm_multi_channel_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the multi-channel pulse-density modulator:
//   - output mode encoding (sigma-delta vs. frame-aligned PWM)
//   - dither LFSR seed and Galois tap mask
//   - clog2_min1: channel-select width that never collapses to zero bits
// -----------------------------------------------------------------------------
package pdm_pkg;

  // Output mode encoding, as seen on mode_pwm / mode_q
  localparam logic MODE_PDM = 1'b0;
  localparam logic MODE_PWM = 1'b1;

  // 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  // The register shifts right; when bit 0 falls out the tap mask is XORed in.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of bits needed to address n items, at least 1 so a
  // single-channel build still has a legal select port.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pdm_multi_channel_channel.sv
// -----------------------------------------------------------------------------
// pdm_channel
// One modulator channel: double-buffered density word (shadow -> active),
// pending flag, first-order sigma-delta accumulator and the output flop.
//
// Ports
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   wr_hit     in  1      write strobe already decoded for this channel
//   wr_data    in  WIDTH  new density word
//   commit     in  1      frame boundary: move shadow to active if pending
//   frame_cnt  in  WIDTH  position inside the current frame
//   mode_q     in  1      frame-latched mode (MODE_PDM / MODE_PWM)
//   dither     in  2      [0] carry-in, [1] saturating decrement (0 when unused)
//   pdm_out    out 1      modulated bit, registered
//   pending    out 1      shadow holds a value not yet committed, registered
// -----------------------------------------------------------------------------
module pdm_channel
  import pdm_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic [WIDTH-1:0] frame_cnt,
  input  logic             mode_q,
  input  logic [1:0]       dither,
  output logic             pdm_out,
  output logic             pending
);

  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] active_r;
  logic [WIDTH-1:0] acc_r;
  logic             pending_r;
  logic             pdm_out_r;
  logic [WIDTH:0]   sum_raw_s;
  logic [WIDTH:0]   sum_s;
  logic             pwm_bit_s;

  // Sigma-delta sum with optional dither; the decrement saturates at zero
  // so the carry can never be produced by an underflow.
  always_comb begin
    sum_raw_s = {1'b0, acc_r} + {1'b0, active_r} + {{WIDTH{1'b0}}, dither[0]};
    if (dither[1] && (sum_raw_s != {(WIDTH+1){1'b0}})) begin
      sum_s = sum_raw_s - {{WIDTH{1'b0}}, 1'b1};
    end else begin
      sum_s = sum_raw_s;
    end
    pwm_bit_s = (frame_cnt < active_r);
  end

  // Shadow buffer and pending flag; a write in the commit cycle wins, so the
  // freshly written word stays pending for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r  <= {WIDTH{1'b0}};
      pending_r <= 1'b0;
    end else if (wr_hit) begin
      shadow_r  <= wr_data;
      pending_r <= 1'b1;
    end else if (commit) begin
      pending_r <= 1'b0;
    end
  end

  // Active word only changes at a frame boundary, taking the pre-write shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= {WIDTH{1'b0}};
    end else if (commit && pending_r) begin
      active_r <= shadow_r;
    end
  end

  // Accumulator runs in both modes and is never cleared, keeping the
  // sigma-delta phase continuous across commits and mode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else begin
      acc_r <= sum_s[WIDTH-1:0];
    end
  end

  // Output flop: carry of the accumulator or the frame-position compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_out_r <= 1'b0;
    end else begin
      case (mode_q)
        MODE_PDM: pdm_out_r <= sum_s[WIDTH];
        MODE_PWM: pdm_out_r <= pwm_bit_s;
        default:  pdm_out_r <= 1'b0;
      endcase
    end
  end

  assign pdm_out = pdm_out_r;
  assign pending = pending_r;

endmodule

// File: rtl/pdm_multi_channel.sv
// -----------------------------------------------------------------------------
// pdm_multi_channel
// Multi-channel pulse-density modulator. Each channel turns a WIDTH-bit
// density word into a 1-bit stream, either by first-order sigma-delta or by a
// frame-aligned compare (PWM). Density words are double-buffered and commit
// only at the last cycle of a 2**WIDTH-cycle frame, so no output glitches
// mid-frame.
//
// Build option: define PDM_DITHER_EN to add a 16-bit Galois LFSR whose two
// low bits dither every channel's sigma-delta sum (PWM path unaffected).
//
// Ports
//   clk          in  1         rising-edge clock
//   reset_n      in  1         asynchronous active-low reset
//   wr_en        in  1         write strobe, one cycle per write
//   wr_chan      in  CH_W      target channel; values >= CHANNELS ignored
//   wr_data      in  WIDTH     new density word
//   mode_pwm     in  1         0 = sigma-delta, 1 = PWM; latched at boundary
//   pdm_out      out CHANNELS  modulated outputs, registered
//   pending      out CHANNELS  shadow value not yet committed, per channel
//   frame_start  out 1         pulse in the first cycle of each frame
// -----------------------------------------------------------------------------
module pdm_multi_channel
  import pdm_pkg::*;
#(
  parameter int  WIDTH    = 5,
  parameter int  CHANNELS = 4,
  localparam int CH_W     = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                mode_pwm,
  output logic [CHANNELS-1:0] pdm_out,
  output logic [CHANNELS-1:0] pending,
  output logic                frame_start
);

  logic [WIDTH-1:0]    frame_cnt_r;
  logic                frame_start_r;
  logic                mode_q_r;
  logic                boundary_s;
  logic                in_range_s;
  logic [CHANNELS-1:0] wr_hit_s;
  logic [1:0]          dither_s;

  // Last cycle of the frame is the commit point.
  always_comb begin
    boundary_s = (frame_cnt_r == {WIDTH{1'b1}});
    in_range_s = (32'(wr_chan) < CHANNELS);
  end

  // One-hot write decode; out-of-range selects hit nothing.
  always_comb begin
    wr_hit_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_en && in_range_s && (32'(wr_chan) == c)) begin
        wr_hit_s[c] = 1'b1;
      end else begin
        wr_hit_s[c] = 1'b0;
      end
    end
  end

  // Free-running frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= {WIDTH{1'b0}};
    end else begin
      frame_cnt_r <= frame_cnt_r + WIDTH'(1);
    end
  end

  // frame_start is registered off the boundary so it is high exactly while
  // frame_cnt is 0; mode is latched at the same boundary as the data commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_r <= 1'b0;
      mode_q_r      <= MODE_PDM;
    end else begin
      frame_start_r <= boundary_s;
      if (boundary_s) begin
        mode_q_r <= mode_pwm;
      end
    end
  end

`ifdef PDM_DITHER_EN
  logic [15:0] lfsr_r;

  // Dither source; seeded rather than cleared so it can never lock up at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= LFSR_SEED;
    end else if (lfsr_r[0]) begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ LFSR_TAPS;
    end else begin
      lfsr_r <= {1'b0, lfsr_r[15:1]};
    end
  end

  assign dither_s = lfsr_r[1:0];
`else
  assign dither_s = 2'b00;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pdm_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (reset_n),
      .wr_hit    (wr_hit_s[g]),
      .wr_data   (wr_data),
      .commit    (boundary_s),
      .frame_cnt (frame_cnt_r),
      .mode_q    (mode_q_r),
      .dither    (dither_s),
      .pdm_out   (pdm_out[g]),
      .pending   (pending[g])
    );
  end

  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_pdm_multi_channel.sv
module tb_pdm_multi_channel;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_chan = 2'd0;
  logic [4:0] wr_data = 5'd0;
  logic       mode_pwm = 1'b0;
  logic [3:0] pdm_out;
  logic [3:0] pending;
  logic       frame_start;

  logic       wr_en3 = 1'b0;
  logic [1:0] wr_chan3 = 2'd0;
  logic [4:0] wr_data3 = 5'd0;
  logic [2:0] pdm_out3;
  logic [2:0] pending3;
  logic       frame_start3;

  always #5 clk = ~clk;

  pdm_multi_channel #(.WIDTH(5), .CHANNELS(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_data(wr_data), .mode_pwm(mode_pwm), .pdm_out(pdm_out),
    .pending(pending), .frame_start(frame_start)
  );

  pdm_multi_channel #(.WIDTH(5), .CHANNELS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en3), .wr_chan(wr_chan3),
    .wr_data(wr_data3), .mode_pwm(1'b0), .pdm_out(pdm_out3),
    .pending(pending3), .frame_start(frame_start3)
  );

  int n_pass = 0;
  int n_total = 0;

  // scoreboard entries: {pdm_out[3:0], pending[3:0], frame_start}
  logic [8:0] sb_q[$];

  // reference model of the 4-channel instance
  int m_cnt;
  bit m_mode;
  bit m_fs;
  int m_shadow[4];
  int m_active[4];
  int m_acc[4];
  bit m_pend[4];
  bit m_out[4];

  task automatic model_reset();
    m_cnt = 0; m_mode = 1'b0; m_fs = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_shadow[c] = 0; m_active[c] = 0; m_acc[c] = 0;
      m_pend[c] = 1'b0; m_out[c] = 1'b0;
    end
  endtask

  // advance the model with the inputs currently driven, queue the expected
  // outputs, then let the DUT take the same clock edge
  task automatic tick();
    logic [8:0] e;
    bit bnd;
    int sum;
    bnd = (m_cnt == 31);
    for (int c = 0; c < 4; c++) begin
      sum = m_acc[c] + m_active[c];
      m_out[c] = m_mode ? (m_cnt < m_active[c]) : (sum >= 32);
      m_acc[c] = sum % 32;
      if (bnd && m_pend[c]) m_active[c] = m_shadow[c];
      if (wr_en && (int'(wr_chan) == c)) begin
        m_shadow[c] = int'(wr_data);
        m_pend[c] = 1'b1;
      end else if (bnd) begin
        m_pend[c] = 1'b0;
      end
    end
    if (bnd) m_mode = mode_pwm;
    m_fs = bnd;
    m_cnt = (m_cnt + 1) % 32;
    for (int c = 0; c < 4; c++) begin
      e[5+c] = m_out[c];
      e[1+c] = m_pend[c];
    end
    e[0] = m_fs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    wr_en3 = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    int first_fs;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({pdm_out, pending, frame_start} !== 9'd0) $display("FAIL reset_held got %b want 0", {pdm_out, pending, frame_start});
    else n_pass++;
    n_total++;
    if ({pdm_out3, pending3, frame_start3} !== 7'd0) $display("FAIL reset_held3 got %b want 0", {pdm_out3, pending3, frame_start3});
    else n_pass++;
    model_reset();
    reset_n = 1'b1;
    first_fs = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_reset cyc %0d got %b want %b", i, {pdm_out, pending, frame_start}, e);
      else n_pass++;
      if (frame_start === 1'b1 && first_fs == 0) first_fs = i;
    end
    n_total++;
    if (first_fs != 32) $display("FAIL first_frame_start got cycle %0d want 32", first_fs);
    else n_pass++;
  endtask

  task automatic test_pdm_low();
    logic [8:0] e;
    int n, highs, last;
    mode_pwm = 1'b0;
    wr_en = 1'b1; wr_chan = 2'd0; wr_data = 5'h08;
    tick();
    e = sb_q.pop_front();
    n_total++;
    if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_low_wr got %b want %b", {pdm_out, pending, frame_start}, e);
    else n_pass++;
    n_total++;
    if (pending[0] !== 1'b1) $display("FAIL low_pending_set got %b want 1", pending[0]);
    else n_pass++;
    n = 32 - m_cnt + 1;
    highs = 0; last = -1;
    for (int i = 0; i < n + 32; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_low cyc %0d got %b want %b", i, {pdm_out, pending, frame_start}, e);
      else n_pass++;
      if (i >= n && pdm_out[0] === 1'b1) begin
        n_total++;
        if (last >= 0 && i - last != 4) $display("FAIL low_spacing got %0d want 4", i - last);
        else n_pass++;
        last = i;
        highs++;
      end
    end
    n_total++;
    if (pending[0] !== 1'b0) $display("FAIL low_pending_clr got %b want 0", pending[0]);
    else n_pass++;
    n_total++;
    if (highs != 8) $display("FAIL low_density got %0d want 8", highs);
    else n_pass++;
  endtask

  task automatic test_pdm_dense();
    logic [8:0] e;
    int n, h0, h1;
    wr_en = 1'b1; wr_chan = 2'd1; wr_data = 5'h1a;
    tick();
    e = sb_q.pop_front();
    n_total++;
    if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_dense_wr got %b want %b", {pdm_out, pending, frame_start}, e);
    else n_pass++;
    n = 32 - m_cnt + 1;
    for (int i = 0; i < n; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_dense_lead cyc %0d got %b want %b", i, {pdm_out, pending, frame_start}, e);
      else n_pass++;
    end
    for (int w = 0; w < 2; w++) begin
      h0 = 0; h1 = 0;
      for (int i = 0; i < 32; i++) begin
        tick();
        e = sb_q.pop_front();
        n_total++;
        if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_dense cyc %0d got %b want %b", i, {pdm_out, pending, frame_start}, e);
        else n_pass++;
        h0 += int'(pdm_out[0]);
        h1 += int'(pdm_out[1]);
      end
      n_total++;
      if (h1 != 26) $display("FAIL dense_ch1 window %0d got %0d want 26", w, h1);
      else n_pass++;
      n_total++;
      if (h0 != 8) $display("FAIL dense_ch0 window %0d got %0d want 8", w, h0);
      else n_pass++;
    end
  endtask

  task automatic test_pwm();
    logic [8:0] e;
    int n, k;
    bit want;
    mode_pwm = 1'b1;
    wr_en = 1'b1; wr_chan = 2'd2; wr_data = 5'h04;
    tick();
    e = sb_q.pop_front();
    n_total++;
    if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_pwm_wr got %b want %b", {pdm_out, pending, frame_start}, e);
    else n_pass++;
    n = 32 - m_cnt;
    for (int i = 0; i < n + 64; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_pwm cyc %0d got %b want %b", i, {pdm_out, pending, frame_start}, e);
      else n_pass++;
      if (i >= n) begin
        // output shows the compare of the previous frame position
        k = m_cnt;
        want = (k >= 1 && k <= 4);
        n_total++;
        if (pdm_out[2] !== want) $display("FAIL pwm_ch2 pos %0d got %b want %b", k, pdm_out[2], want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    int h;
    for (int i = 0; i < 32 && m_cnt != 10; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_b2b_a got %b want %b", {pdm_out, pending, frame_start}, e);
      else n_pass++;
    end
    wr_en = 1'b1; wr_chan = 2'd3; wr_data = 5'h0f;
    for (int i = 0; i < 32 && (i == 0 || m_cnt != 31); i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_b2b_b got %b want %b", {pdm_out, pending, frame_start}, e);
      else n_pass++;
    end
    // second write lands on the commit edge
    wr_en = 1'b1; wr_chan = 2'd3; wr_data = 5'h04;
    tick();
    e = sb_q.pop_front();
    n_total++;
    if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_b2b_commit got %b want %b", {pdm_out, pending, frame_start}, e);
    else n_pass++;
    n_total++;
    if (pending[3] !== 1'b1) $display("FAIL b2b_pending_kept got %b want 1", pending[3]);
    else n_pass++;
    for (int f = 0; f < 2; f++) begin
      h = 0;
      for (int i = 0; i < 32; i++) begin
        tick();
        e = sb_q.pop_front();
        n_total++;
        if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_b2b frame %0d got %b want %b", f, {pdm_out, pending, frame_start}, e);
        else n_pass++;
        h += int'(pdm_out[3]);
      end
      n_total++;
      if (h != ((f == 0) ? 15 : 4)) $display("FAIL b2b_frame%0d_highs got %0d want %0d", f, h, (f == 0) ? 15 : 4);
      else n_pass++;
    end
    n_total++;
    if (pending[3] !== 1'b0) $display("FAIL b2b_pending_clr got %b want 0", pending[3]);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [8:0] e;
    wr_en3 = 1'b1; wr_chan3 = 2'd3; wr_data3 = 5'h1f;
    for (int i = 0; i < 40; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_oor got %b want %b", {pdm_out, pending, frame_start}, e);
      else n_pass++;
      n_total++;
      if ({pdm_out3, pending3} !== 6'd0) $display("FAIL oor_ignored cyc %0d got %b want 0", i, {pdm_out3, pending3});
      else n_pass++;
    end
    wr_en3 = 1'b1; wr_chan3 = 2'd2; wr_data3 = 5'h10;
    tick();
    e = sb_q.pop_front();
    n_total++;
    if (pending3 !== 3'b100) $display("FAIL oor_inrange_write got %b want 100", pending3);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] e;
    wr_en = 1'b1; wr_chan = 2'd0; wr_data = 5'h03;
    tick();
    e = sb_q.pop_front();
    n_total++;
    if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_rst_wr got %b want %b", {pdm_out, pending, frame_start}, e);
    else n_pass++;
    #3;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({pdm_out, pending, frame_start} !== 9'd0) $display("FAIL rst_async got %b want 0", {pdm_out, pending, frame_start});
    else n_pass++;
    n_total++;
    if ({pdm_out3, pending3, frame_start3} !== 7'd0) $display("FAIL rst_async3 got %b want 0", {pdm_out3, pending3, frame_start3});
    else n_pass++;
    sb_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = sb_q.pop_front();
      n_total++;
      if ({pdm_out, pending, frame_start} !== e) $display("FAIL sb_post_rst cyc %0d got %b want %b", i, {pdm_out, pending, frame_start}, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pdm_low();
    test_pdm_dense();
    test_pwm();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
